// File: rtl/aes_cbcmac_rtkey.sv
// aes_cbcmac_rtkey: compresses 1..2^BLOCKS_W raw 128-bit entropy blocks into
// one 128-bit CBC-MAC using AES-128 with a run-time loadable master key.
// One full AES round is computed per clock. Round keys are expanded on the
// fly from the previous round key, so no key table is stored.
// Optional feature: define AES_CBCMAC_ZEROIZE_EN to add a synchronous
// i_zeroize input that wipes all key and data material in one edge.
module aes_cbcmac_rtkey #(
   parameter int          BLOCKS_W  = 4,
   parameter logic [127:0] RESET_KEY = 128'h0
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic                i_key_valid,
   input  logic [127:0]        i_key,
   input  logic [BLOCKS_W-1:0] i_blocks,
   input  logic                i_valid,
   input  logic [127:0]        i_dat,
   output logic                o_ready,
   output logic                o_key_ready,
   output logic [127:0]        o_dat,
   output logic                o_valid,
   input  logic                i_read
`ifdef AES_CBCMAC_ZEROIZE_EN
   ,
   input  logic                i_zeroize
`endif
);

   typedef enum logic [1:0] {IDLE, ROUND, OUT} fsmState_e;

   // Multiply by x in GF(2^8) with the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // General GF(2^8) multiply, shift-and-add.
   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // AES S-box: multiplicative inverse as x^254 (0 maps to 0), then affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gfMul(sq, sq);
         inv = gfMul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // SubBytes followed by ShiftRows. Byte k sits at bits [127-8k -: 8],
   // byte k = row + 4*column, so row r of column c comes from column c+r.
   function automatic logic [127:0] subShift(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            r[127-8*(row+4*c) -: 8] = sbox(s[127-8*(row+4*((c+row)%4)) -: 8]);
         end
      end
      return r;
   endfunction

   // MixColumns on all four columns.
   function automatic logic [127:0] mixColumns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
      return r;
   endfunction

   // One step of the AES-128 key schedule using four S-boxes.
   function automatic logic [127:0] expandKey(input logic [127:0] rk, input logic [7:0] rcon);
      logic [31:0] rot;
      logic [31:0] temp;
      logic [31:0] n0, n1, n2, n3;
      rot  = {rk[23:0], rk[31:24]};
      temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
             ^ {rcon, 24'h000000};
      n0 = rk[127:96] ^ temp;
      n1 = rk[95:64]  ^ n0;
      n2 = rk[63:32]  ^ n1;
      n3 = rk[31:0]   ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   fsmState_e           fsm_q, fsm_d;
   logic [127:0]        aesState_q, aesState_d;
   logic [127:0]        rk_q, rk_d;
   logic [7:0]          rcon_q, rcon_d;
   logic [3:0]          rnd_q, rnd_d;
   logic [127:0]        chain_q, chain_d;
   logic [BLOCKS_W-1:0] blkCnt_q, blkCnt_d;
   logic [BLOCKS_W-1:0] blkLast_q, blkLast_d;
   logic [127:0]        mkey_q, mkey_d;
   logic [127:0]        oDat_q, oDat_d;
   logic                oValid_q, oValid_d;

   logic         zeroize;
   logic         keyLoad;
   logic         blkAccept;
   logic         lastRound;
   logic         lastBlock;
   logic [127:0] roundKey;
   logic [127:0] roundOut;
   logic [127:0] roundResult;

`ifdef AES_CBCMAC_ZEROIZE_EN
   assign zeroize = i_zeroize;
`else
   assign zeroize = 1'b0;
`endif

   // A key load takes precedence over a block offered on the same edge.
   assign keyLoad     = i_key_valid && o_key_ready;
   assign blkAccept   = i_valid && o_ready && !keyLoad;
   assign lastRound   = (rnd_q == 4'd10);
   assign lastBlock   = (blkCnt_q == blkLast_q);
   assign roundKey    = expandKey(rk_q, rcon_q);
   assign roundOut    = subShift(aesState_q);
   assign roundResult = (lastRound ? roundOut : mixColumns(roundOut)) ^ roundKey;
   assign o_dat       = oDat_q;
   assign o_valid     = oValid_q;

   // State register: every flop of the block, cleared asynchronously.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         fsm_q      <= IDLE;
         aesState_q <= '0;
         rk_q       <= '0;
         rcon_q     <= 8'h01;
         rnd_q      <= 4'd1;
         chain_q    <= '0;
         blkCnt_q   <= '0;
         blkLast_q  <= '0;
         mkey_q     <= RESET_KEY;
         oDat_q     <= '0;
         oValid_q   <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         aesState_q <= aesState_d;
         rk_q       <= rk_d;
         rcon_q     <= rcon_d;
         rnd_q      <= rnd_d;
         chain_q    <= chain_d;
         blkCnt_q   <= blkCnt_d;
         blkLast_q  <= blkLast_d;
         mkey_q     <= mkey_d;
         oDat_q     <= oDat_d;
         oValid_q   <= oValid_d;
      end
   end

   // Next FSM state: idle until a block is taken, ten rounds, then either
   // back to idle for the next block or hold the result until it is read.
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE:    if (blkAccept) fsm_d = ROUND;
         ROUND:   if (lastRound) fsm_d = lastBlock ? OUT : IDLE;
         OUT:     if (i_read) fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
      if (zeroize) fsm_d = IDLE;
   end

   // Handshake outputs: blocks only in IDLE, keys only before a message starts.
   always_comb begin
      o_ready     = 1'b0;
      o_key_ready = 1'b0;
      if (fsm_q == IDLE) begin
         o_ready     = 1'b1;
         o_key_ready = (blkCnt_q == '0);
      end
   end

   // Datapath next values: block whitening, round/key-schedule step, chaining
   // and result capture; zeroize overrides everything.
   always_comb begin
      aesState_d = aesState_q;
      rk_d       = rk_q;
      rcon_d     = rcon_q;
      rnd_d      = rnd_q;
      chain_d    = chain_q;
      blkCnt_d   = blkCnt_q;
      blkLast_d  = blkLast_q;
      mkey_d     = mkey_q;
      oDat_d     = oDat_q;
      oValid_d   = oValid_q;
      case (fsm_q)
         IDLE: begin
            if (keyLoad) begin
               mkey_d  = i_key;
               chain_d = '0;
            end else if (blkAccept) begin
               aesState_d = i_dat ^ chain_q ^ mkey_q;
               rk_d       = mkey_q;
               rcon_d     = 8'h01;
               rnd_d      = 4'd1;
               if (blkCnt_q == '0) blkLast_d = i_blocks;
            end
         end
         ROUND: begin
            rk_d       = roundKey;
            rcon_d     = xtime(rcon_q);
            aesState_d = roundResult;
            rnd_d      = rnd_q + 4'd1;
            if (lastRound) begin
               chain_d = roundResult;
               if (lastBlock) begin
                  oDat_d   = roundResult;
                  oValid_d = 1'b1;
                  blkCnt_d = '0;
               end else begin
                  blkCnt_d = blkCnt_q + 1'b1;
               end
            end
         end
         OUT: begin
            if (i_read) begin
               oValid_d = 1'b0;
               chain_d  = '0;
            end
         end
         default: ;
      endcase
      if (zeroize) begin
         aesState_d = '0;
         rk_d       = '0;
         chain_d    = '0;
         oDat_d     = '0;
         oValid_d   = 1'b0;
         mkey_d     = RESET_KEY;
         blkCnt_d   = '0;
      end
   end

endmodule
